// File: rtl/pitch_ram_sched.sv
// Pitch-shift sequencer for a single-port buffer RAM with 1-cycle read latency.
// Per sample strobe it writes the sample, reads two taps half a buffer apart and crossfades them.
module pitch_ram_sched #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int FRAC_W = 4
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  input  logic [7:0]        step,
  input  logic              bypass,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] sample_out,
  output logic              out_valid
);

  localparam int PTR_W  = ADDR_W + FRAC_W;
  localparam int PROD_W = DATA_W + ADDR_W + 1;
  localparam logic [ADDR_W-1:0] HALF   = {1'b1, {(ADDR_W-1){1'b0}}};
  localparam logic [ADDR_W:0]   FULL   = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RDA, S_RDB, S_MIX, S_OUT} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [DATA_W-1:0] sample_reg;
  logic [7:0]        step_reg;
  logic              bypass_reg;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] sample_out_reg;
  logic              out_valid_reg;

  logic [ADDR_W-1:0]        tap_a, tap_b, dist_a;
  logic [ADDR_W:0]          w_a, w_b;
  logic signed [PROD_W-1:0] a_ext, b_ext, wa_ext, wb_ext, mix_sum, mix_shift;
  logic [DATA_W-1:0]        mix_y;

  assign tap_a  = rd_ptr_reg[PTR_W-1:FRAC_W];
  assign tap_b  = tap_a + HALF;
  assign dist_a = wr_ptr_reg - tap_a;

  // Tap weight is its circular distance to the write pointer, folded into 0..N/2
  assign w_a = dist_a[ADDR_W-1] ? (FULL - {1'b0, dist_a}) : {1'b0, dist_a};
  assign w_b = {1'b0, HALF} - w_a;

  // ram_rdata carries tap B during MIX; weights sum to N/2 so the sum cannot overflow
  assign a_ext     = {{(ADDR_W+1){a_reg[DATA_W-1]}}, a_reg};
  assign b_ext     = {{(ADDR_W+1){ram_rdata[DATA_W-1]}}, ram_rdata};
  assign wa_ext    = {{(PROD_W-ADDR_W-1){1'b0}}, w_a};
  assign wb_ext    = {{(PROD_W-ADDR_W-1){1'b0}}, w_b};
  assign mix_sum   = a_ext * wa_ext + b_ext * wb_ext;
  assign mix_shift = mix_sum >>> (ADDR_W - 1);
  assign mix_y     = mix_shift[DATA_W-1:0];

  always_comb begin
    state_next = state_reg;
    ram_addr   = '0;
    ram_we     = 1'b0;
    ram_wdata  = '0;
    case (state_reg)
      S_IDLE: if (sample_valid) state_next = S_WR;
      S_WR: begin
        ram_addr   = wr_ptr_reg;
        ram_we     = 1'b1;
        ram_wdata  = sample_reg;
        state_next = S_RDA;
      end
      S_RDA: begin
        ram_addr   = tap_a;
        state_next = S_RDB;
      end
      S_RDB: begin
        ram_addr   = tap_b;
        state_next = S_MIX;
      end
      S_MIX:   state_next = S_OUT;
      S_OUT:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      sample_reg     <= '0;
      step_reg       <= '0;
      bypass_reg     <= 1'b0;
      a_reg          <= '0;
      sample_out_reg <= '0;
      out_valid_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= (state_reg == S_MIX);
      case (state_reg)
        S_IDLE: if (sample_valid) begin
          sample_reg <= sample_in;
          step_reg   <= step;
          bypass_reg <= bypass;
        end
        S_RDB: a_reg <= ram_rdata;
        S_MIX: sample_out_reg <= bypass_reg ? sample_reg : mix_y;
        S_OUT: begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
          // Bypass parks the read tap at maximum delay so leaving bypass is seamless
          if (bypass_reg)
            rd_ptr_reg <= {wr_ptr_reg + ADDR_W'(2), {FRAC_W{1'b0}}};
          else
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(step_reg);
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state_reg != S_IDLE);
  assign sample_out = sample_out_reg;
  assign out_valid  = out_valid_reg;

endmodule

// File: tb/tb_pitch_ram_sched.sv
// Directed bench for pitch_ram_sched with a behavioural 1-cycle-latency RAM.
module tb_pitch_ram_sched;

  logic        Clk = 1'b0;
  logic        reset = 1'b0;
  logic        sample_valid = 1'b0;
  logic [31:0] sample_in = '0;
  logic [7:0]  step = '0;
  logic        bypass = 1'b0;
  logic        busy;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] sample_out;
  logic        out_valid;

  logic [31:0] mem [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  int errors = 0;
  int checks = 0;

  logic [7:0]  rec_addr  [0:5];
  logic        rec_we    [0:5];
  logic [31:0] rec_wdata [0:5];
  logic        rec_ov    [0:5];
  logic [31:0] rec_out   [0:5];
  logic        rec_busy  [0:5];

  pitch_ram_sched dut (
    .Clk(Clk), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
    .step(step), .bypass(bypass), .busy(busy), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .sample_out(sample_out),
    .out_valid(out_valid)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic poke(input logic [7:0] addr, input logic [31:0] data);
    @(posedge Clk); #1;
    pre_we = 1'b1; pre_addr = addr; pre_data = data;
    @(posedge Clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clk); reset = 1'b0;
    repeat (2) @(negedge Clk);
    reset = 1'b1;
  endtask

  // One strobe; records outputs in cycles t+1..t+5, sampled on the falling edge
  task automatic do_pass(input logic [31:0] s, input logic [7:0] st, input logic byp);
    @(posedge Clk); #1;
    sample_valid = 1'b1; sample_in = s; step = st; bypass = byp;
    @(posedge Clk); #1;
    sample_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge Clk);
      rec_addr[c] = ram_addr; rec_we[c] = ram_we; rec_wdata[c] = ram_wdata;
      rec_ov[c] = out_valid; rec_out[c] = sample_out; rec_busy[c] = busy;
    end
    $display("pass: in=%h step=%h byp=%0d wr_addr=%0d rda=%0d rdb=%0d out=%h",
             s, st, byp, rec_addr[1], rec_addr[2], rec_addr[3], rec_out[5]);
  endtask

  task automatic test_reset();
    logic seen_ov;
    reset = 1'b0;
    repeat (2) @(negedge Clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", ram_we); end
    checks++; if (ram_addr !== 8'd0) begin errors++; $display("FAIL reset_addr got=%h exp=0", ram_addr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_ov got=%b exp=0", out_valid); end
    checks++; if (sample_out !== 32'd0) begin errors++; $display("FAIL reset_out got=%h exp=0", sample_out); end
    reset = 1'b1;
    do_pass(32'h0000ABCD, 8'h10, 1'b1);
    checks++; if (rec_out[5] !== 32'h0000ABCD) begin errors++; $display("FAIL pre_abort_out got=%h exp=0000abcd", rec_out[5]); end
    // Second pass aborted by reset during RDB
    @(posedge Clk); #1;
    sample_valid = 1'b1; sample_in = 32'h5555; bypass = 1'b0;
    @(posedge Clk); #1;
    sample_valid = 1'b0;
    @(negedge Clk);
    checks++; if (ram_addr !== 8'd1) begin errors++; $display("FAIL abort_wr_addr got=%0d exp=1", ram_addr); end
    @(negedge Clk);
    @(negedge Clk);
    #1 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (ram_addr !== 8'd0) begin errors++; $display("FAIL abort_addr got=%h exp=0", ram_addr); end
    checks++; if (sample_out !== 32'd0) begin errors++; $display("FAIL abort_out got=%h exp=0", sample_out); end
    seen_ov = out_valid;
    repeat (6) begin
      @(negedge Clk);
      seen_ov = seen_ov | out_valid;
    end
    checks++; if (seen_ov !== 1'b0) begin errors++; $display("FAIL abort_no_ov got=%b exp=0", seen_ov); end
    reset = 1'b1;
    do_pass(32'h00000077, 8'h10, 1'b0);
    checks++; if (rec_addr[1] !== 8'd0) begin errors++; $display("FAIL post_reset_wr_addr got=%0d exp=0", rec_addr[1]); end
    checks++; if (rec_wdata[1] !== 32'h77) begin errors++; $display("FAIL post_reset_wdata got=%h exp=77", rec_wdata[1]); end
  endtask

  task automatic test_bypass();
    logic early_ov;
    do_reset();
    do_pass(32'h00001234, 8'h10, 1'b1);
    checks++; if (rec_busy[1] !== 1'b1) begin errors++; $display("FAIL byp_busy got=%b exp=1", rec_busy[1]); end
    checks++; if (rec_addr[1] !== 8'd0) begin errors++; $display("FAIL byp_wr_addr got=%0d exp=0", rec_addr[1]); end
    checks++; if (rec_we[1] !== 1'b1) begin errors++; $display("FAIL byp_we got=%b exp=1", rec_we[1]); end
    checks++; if (rec_wdata[1] !== 32'h00001234) begin errors++; $display("FAIL byp_wdata got=%h exp=00001234", rec_wdata[1]); end
    early_ov = rec_ov[1] | rec_ov[2] | rec_ov[3] | rec_ov[4];
    checks++; if (early_ov !== 1'b0) begin errors++; $display("FAIL byp_early_ov got=%b exp=0", early_ov); end
    checks++; if (rec_ov[5] !== 1'b1) begin errors++; $display("FAIL byp_ov got=%b exp=1", rec_ov[5]); end
    checks++; if (rec_out[5] !== 32'h00001234) begin errors++; $display("FAIL byp_out got=%h exp=00001234", rec_out[5]); end
    do_pass(32'h0, 8'h10, 1'b0);
    checks++; if (rec_addr[1] !== 8'd1) begin errors++; $display("FAIL realign_wr got=%0d exp=1", rec_addr[1]); end
    checks++; if (rec_addr[2] !== 8'd2) begin errors++; $display("FAIL realign_rda got=%0d exp=2", rec_addr[2]); end
    checks++; if (rec_we[2] !== 1'b0) begin errors++; $display("FAIL rda_we got=%b exp=0", rec_we[2]); end
  endtask

  task automatic test_unity();
    do_reset();
    poke(8'd128, 32'h100);
    poke(8'd129, 32'h55);
    do_pass(32'h999, 8'h10, 1'b0);
    checks++; if (rec_addr[2] !== 8'd0) begin errors++; $display("FAIL unity_rda got=%0d exp=0", rec_addr[2]); end
    checks++; if (rec_addr[3] !== 8'd128) begin errors++; $display("FAIL unity_rdb got=%0d exp=128", rec_addr[3]); end
    checks++; if (rec_out[5] !== 32'h100) begin errors++; $display("FAIL unity_out0 got=%h exp=100", rec_out[5]); end
    do_pass(32'h42, 8'h10, 1'b0);
    checks++; if (rec_addr[2] !== 8'd1) begin errors++; $display("FAIL unity_rda1 got=%0d exp=1", rec_addr[2]); end
    checks++; if (rec_out[5] !== 32'h55) begin errors++; $display("FAIL unity_out1 got=%h exp=55", rec_out[5]); end
  endtask

  task automatic test_octave_down();
    logic [7:0]  exp_a   [0:5];
    logic [31:0] ins     [0:5];
    logic [31:0] exp_out [0:2];
    exp_a = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2};
    ins = '{32'h80, 32'hFFFFFF00, 32'h0, 32'h0, 32'h0, 32'h0};
    // (0x80*1 + 0x100*127)>>>7 = 255 ; (-256*1 + 0*127)>>>7 = -2
    exp_out = '{32'h100, 32'hFF, 32'hFFFFFFFE};
    do_reset();
    poke(8'd128, 32'h100);
    poke(8'd129, 32'h0);
    for (int i = 0; i < 6; i++) begin
      do_pass(ins[i], 8'h08, 1'b0);
      checks++;
      if (rec_addr[2] !== exp_a[i]) begin
        errors++; $display("FAIL oct_down_rda[%0d] got=%0d exp=%0d", i, rec_addr[2], exp_a[i]);
      end
      if (i < 3) begin
        checks++;
        if (rec_out[5] !== exp_out[i]) begin
          errors++; $display("FAIL oct_down_out[%0d] got=%h exp=%h", i, rec_out[5], exp_out[i]);
        end
      end
    end
  endtask

  task automatic test_octave_up();
    logic [7:0] exp_a;
    logic [7:0] exp_w;
    do_reset();
    for (int i = 0; i < 258; i++) begin
      do_pass(32'(i), 8'h20, 1'b0);
      exp_a = 8'((2 * i) % 256);
      checks++;
      if (rec_addr[2] !== exp_a) begin
        errors++; $display("FAIL oct_up_rda[%0d] got=%0d exp=%0d", i, rec_addr[2], exp_a);
      end
      if (i == 255 || i == 256) begin
        exp_w = 8'(i % 256);
        checks++;
        if (rec_addr[1] !== exp_w) begin
          errors++; $display("FAIL oct_up_wr[%0d] got=%0d exp=%0d", i, rec_addr[1], exp_w);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_busy [0:7];
    logic bsy [0:7];
    logic ov  [0:7];
    exp_busy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    @(posedge Clk); #1;
    sample_valid = 1'b1; sample_in = 32'h31; step = 8'h10; bypass = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk);
      bsy[c] = busy; ov[c] = out_valid;
      @(posedge Clk); #1;
      sample_valid = (c + 1 == 2);
      sample_in = 32'h99;
    end
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (bsy[c] !== exp_busy[c]) begin
        errors++; $display("FAIL b2b_busy[t+%0d] got=%b exp=%b", c, bsy[c], exp_busy[c]);
      end
      checks++;
      if (ov[c] !== (c == 5)) begin
        errors++; $display("FAIL b2b_ov[t+%0d] got=%b exp=%b", c, ov[c], (c == 5));
      end
    end
    do_pass(32'h5, 8'h10, 1'b0);
    checks++; if (rec_addr[1] !== 8'd1) begin errors++; $display("FAIL b2b_next_wr got=%0d exp=1", rec_addr[1]); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_unity();
    test_octave_down();
    test_octave_up();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pitch_ram_sched.md
Name: pitch_ram_sched

Overview:
Sequencer for the single-address-port pitch buffer RAM, with 1-cycle read latency, used by the vocal pitch effects. It runs one pass per audio sample strobe:
- writes the incoming sample at the write pointer;
- reads two taps half a buffer apart at a fractional read pointer advancing by a programmable step;
- crossfades the two taps by their distance from the write pointer, to suppress wrap clicks.

It replaces fixed up/down pitch blocks with one rate-programmable controller. It sits between the codec sample stream and the output mixer.

Parameters:
ADDR_W, 8, RAM address width; buffer depth N = 2^ADDR_W
DATA_W, 32, signed sample width
FRAC_W, 4, fractional bits of read pointer and step

Ports:
Clk  in  1  system clock
reset  in  1  asynchronous active-low reset
sample_valid  in  1  one-cycle strobe: sample_in valid
sample_in  in  DATA_W  signed input sample
step  in  8  unsigned read step, Q4.4 (0x10 unity, 0x08 octave down, 0x20 octave up, 0x00 freeze)
bypass  in  1  1 = output the dry input sample
busy  out  1  high in every state except IDLE
ram_addr  out  ADDR_W  RAM address
ram_we  out  1  RAM write enable
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid the cycle after address
sample_out  out  DATA_W  signed processed sample (registered)
out_valid  out  1  one-cycle strobe: sample_out updated

Behaviour:
- Reset (async, active-low):
  - state = IDLE; wr_ptr = 0; rd_ptr (ADDR_W+FRAC_W bits) = 0.
  - All outputs 0.
  - Reset mid-pass aborts the pass with no out_valid. RAM contents are not cleared.
- FSM: IDLE -> WR -> RDA -> RDB -> MIX -> OUT -> IDLE. Each state lasts exactly one cycle.
- IDLE: on sample_valid, capture sample_in, step and bypass into registers. These values are used for the whole pass.
- WR: ram_addr = wr_ptr, ram_we = 1, ram_wdata = captured sample.
- RDA: ram_addr = A = rd_ptr[ADDR_W+FRAC_W-1:FRAC_W]; ram_we = 0.
- RDB:
  - ram_addr = B = A + N/2 (mod N).
  - Latch a = ram_rdata.
- MIX:
  - Latch b = ram_rdata.
  - dA = (wr_ptr - A) mod N.
  - wA = (dA < N/2) ? dA : N - dA, giving range 0..N/2; wB = N/2 - wA.
  - y = (a*wA + b*wB) >>> (ADDR_W-1). Signed products are DATA_W+ADDR_W+1 bits wide; truncate y to DATA_W.
  - Overflow is impossible because wA + wB = N/2.
- OUT:
  - sample_out = captured sample if bypass, else y; out_valid = 1 for this cycle only.
  - wr_ptr += 1 (wraps mod N).
  - If bypass: rd_ptr = {wr_ptr+1, FRAC_W'b0}. This realigns to maximum delay so un-bypass is seamless.
  - Otherwise: rd_ptr += step (wraps mod N*2^FRAC_W).
- Latency: sample_valid at cycle t -> out_valid high in cycle t+5. Minimum strobe spacing is 6 cycles.
- sample_valid while busy is dropped: no capture, no state change.
- A == wr_ptr: RDA reads the sample written in WR of the same pass (write-before-read by sequencing). wA = 0, so the output is tap B only.
- step = 0: rd_ptr frozen; writes continue.
- A step change takes effect at the next captured sample.
- ram_we is high only in WR.

Test Plan:
1. Reset mid-pass:
   - Assert reset during RDB -> same-cycle outputs 0, no out_valid.
   - After release, the first pass writes at addr 0.
2. Bypass:
   - bypass=1, sample 0x00001234 at t -> WR at t+1 with ram_addr=0, ram_wdata=0x00001234.
   - out_valid at t+5 with sample_out=0x00001234.
   - Next pass reads A=2 (rd realigned to wr_ptr+1=2, wr_ptr=1).
3. Unity crossfade, from reset with step=0x10 and RAM model holding 0x100 at addr 128:
   - First sample: A=0, B=128, wA=0, wB=128 -> sample_out=0x100.
   - Next pass: A=1, wr_ptr=1, dA=0 -> tap B only.
4. Octave down, step=0x08 -> RDA ram_addr sequence 0,0,1,1,2,2 over six passes.
5. Octave up wrap, step=0x20:
   - RDA addresses 0,2,4,...,254,0,2 (wrap after 128 passes).
   - wr_ptr wraps 255->0 after 256 passes.
6. Busy drop: sample_valid at t and t+2 -> only one pass, one out_valid at t+5; busy high t+1..t+5.
